// File: rtl/tap_if.sv
// Button tap bus: press pulses and enable in, completed tap-group reports out.
interface tap_if #(
    parameter int MAX_TAPS = 3
);
    localparam int TAP_W = $clog2(MAX_TAPS + 1);

    logic             pos_edge;
    logic             enable;
    logic             tap_valid;
    logic [TAP_W-1:0] tap_count;
    logic             busy;

    modport master (
        output pos_edge, enable,
        input  tap_valid, tap_count, busy
    );

    modport slave (
        input  pos_edge, enable,
        output tap_valid, tap_count, busy
    );
endinterface

// File: rtl/tap_decoder.sv
// Groups debounced press pulses into single/double/... taps with a post-press lockout,
// reporting each finished group as a one-cycle tap_valid plus its tap_count.
module tap_decoder #(
    parameter int LOCKOUT_CYCLES = 1000,
    parameter int WINDOW_CYCLES  = 50000,
    parameter int MAX_TAPS       = 3,
    parameter int TIMER_W        = 16
) (
    input  logic clk,
    input  logic nrst,
    tap_if.slave bus
);
    localparam int TAP_W = $clog2(MAX_TAPS + 1);

    localparam logic [TIMER_W-1:0] LOCK_LAST = TIMER_W'(LOCKOUT_CYCLES - 1);
    localparam logic [TIMER_W-1:0] WIN_LAST  = TIMER_W'(WINDOW_CYCLES - 1);
    localparam logic [TAP_W-1:0]   TAPS_MAX  = TAP_W'(MAX_TAPS);

    typedef enum logic [1:0] {IDLE, LOCKOUT, WINDOW, REPORT} state_t;

    state_t             state;
    logic [TAP_W-1:0]   count;
    logic [TIMER_W-1:0] timer;
    logic [TAP_W-1:0]   tap_count_q;

    // NOTE: all state updates use non-blocking assignments so every register samples
    // pre-edge values; the async reset clears the whole FSM, including the held report.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state       <= IDLE;
            count       <= '0;
            timer       <= '0;
            tap_count_q <= '0;
        end else if (!bus.enable && (state == LOCKOUT || state == WINDOW)) begin
            // Abort silently; the previous report stays visible on tap_count.
            state <= IDLE;
            count <= '0;
            timer <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.pos_edge && bus.enable) begin
                        count <= TAP_W'(1);
                        timer <= '0;
                        state <= LOCKOUT;
                    end
                end
                LOCKOUT: begin
                    if (timer == LOCK_LAST) begin
                        timer <= '0;
                        if (count == TAPS_MAX) begin
                            tap_count_q <= count;
                            state       <= REPORT;
                        end else begin
                            state <= WINDOW;
                        end
                    end else begin
                        timer <= timer + TIMER_W'(1);
                    end
                end
                WINDOW: begin
                    // A press on the final window cycle still extends the group.
                    if (bus.pos_edge) begin
                        count <= count + TAP_W'(1);
                        timer <= '0;
                        state <= LOCKOUT;
                    end else if (timer == WIN_LAST) begin
                        timer       <= '0;
                        tap_count_q <= count;
                        state       <= REPORT;
                    end else begin
                        timer <= timer + TIMER_W'(1);
                    end
                end
                REPORT: begin
                    count <= '0;
                    timer <= '0;
                    state <= IDLE;
                end
                default: begin
                    count <= '0;
                    timer <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.tap_valid = (state == REPORT);
    assign bus.busy      = (state != IDLE);
    assign bus.tap_count = tap_count_q;

endmodule
